// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Request bundle, FSM states and grant encoding.
package wb_arb_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic {
        PIPE_PRIO,
        FORCE_LL
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_LL
    } gnt_e;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        return 32'b1 << rd;
    endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Long-latency result FIFO with per-entry valid bits.
// Entries can be killed by rd match; pending mask is the live rd set.
module wb_ll_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic [4:0]      push_rd,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    input  logic            inv_en,
    input  logic [4:0]      inv_rd,
    output logic            empty,
    output logic            full,
    output wb_req_t         head,
    output logic [31:0]     pending
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_req_t     mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer/entry update; a push lands after any kill so it survives.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (inv_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].rd == inv_rd) begin
                        mem[i].valid <= 1'b0;
                    end
                end
            end
            if (pop) begin
                mem[rd_ptr[AW-1:0]].valid <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= '{1'b1, push_rd, push_data};
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Live destination mask; popped entries have valid cleared.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid) begin
                pending = pending | rd_onehot(mem[i].rd);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order writeback vs LL returns.
// Pipe has priority; a starved or full LL queue forces one LL slot.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int LL_DEPTH = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_stall,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     ll_pending
);

    localparam int AGEW = $clog2(MAX_WAIT) + 1;

    arb_state_e      state;
    arb_state_e      state_nxt;
    gnt_e            gnt;
    logic [AGEW-1:0] age;
    logic [AGEW-1:0] age_nxt;
    logic            fifo_empty;
    logic            fifo_full;
    wb_req_t         head;
    logic            pipe_req;
    logic            push;
    logic            we_nxt;
    logic [4:0]      waddr_nxt;
    logic [XLEN-1:0] wdata_nxt;

    // x0 writes are consumed without needing the port.
    assign pipe_req   = pipe_valid && (pipe_rd != 5'd0);
    assign ll_ready   = !fifo_full;
    assign push       = ll_valid && ll_ready && (ll_rd != 5'd0);
    assign pipe_stall = pipe_req && (gnt != GNT_PIPE);

    wb_ll_fifo #(
        .DEPTH(LL_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_rd  (ll_rd),
        .push_data(ll_data),
        .pop      (gnt == GNT_LL),
        .inv_en   (gnt == GNT_PIPE),
        .inv_rd   (pipe_rd),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .head     (head),
        .pending  (ll_pending)
    );

    // Grant selection, head age tracking and next state.
    always_comb begin
        gnt       = GNT_NONE;
        state_nxt = state;
        age_nxt   = age;
        unique case (state)
            PIPE_PRIO: begin
                if (pipe_req) begin
                    gnt = GNT_PIPE;
                end else if (!fifo_empty) begin
                    gnt = GNT_LL;
                end
                if (!fifo_empty && (gnt != GNT_LL)) begin
                    age_nxt = age + 1'b1;
                    if ((age == AGEW'(MAX_WAIT - 1)) || fifo_full) begin
                        state_nxt = FORCE_LL;
                    end
                end
            end
            FORCE_LL: begin
                state_nxt = PIPE_PRIO;
                if (!fifo_empty) begin
                    gnt = GNT_LL;
                end else if (pipe_req) begin
                    gnt = GNT_PIPE;
                end
            end
        endcase
        if (gnt == GNT_LL) begin
            age_nxt = '0;
        end
    end

    // Write-port mux; killed LL entries burn the slot silently.
    always_comb begin
        we_nxt    = 1'b0;
        waddr_nxt = '0;
        wdata_nxt = '0;
        unique case (1'b1)
            (gnt == GNT_PIPE): begin
                we_nxt    = 1'b1;
                waddr_nxt = pipe_rd;
                wdata_nxt = pipe_data;
            end
            (gnt == GNT_LL && head.valid): begin
                we_nxt    = 1'b1;
                waddr_nxt = head.rd;
                wdata_nxt = head.data;
            end
            default: begin
                we_nxt = 1'b0;
            end
        endcase
    end

    // FSM/age state and the registered write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= PIPE_PRIO;
            age      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state    <= state_nxt;
            age      <= age_nxt;
            rf_we    <= we_nxt;
            rf_waddr <= waddr_nxt;
            rf_wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter.
// Expected writes are queued with their cycle; a monitor matches them.
module tb_wb_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] ll_pending;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt   = 0;
    int   tests_run = 0;
    int   failed    = 0;

    wb_port_arbiter #(
        .LL_DEPTH(4),
        .MAX_WAIT(8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pipe_valid(pipe_valid),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .pipe_stall(pipe_stall),
        .ll_valid  (ll_valid),
        .ll_ready  (ll_ready),
        .ll_rd     (ll_rd),
        .ll_data   (ll_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .ll_pending(ll_pending)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard monitor: every write must match an expected cycle.
    always @(negedge clock) begin
        int hit;
        hit = -1;
        if (rf_we === 1'b1) begin
            foreach (sb[i]) begin
                if (hit < 0 && sb[i].cyc == cyc_cnt) hit = i;
            end
            tests_run++;
            if (hit < 0) begin
                failed++;
                $display("FAIL rf_write cyc=%0d got x%0d=%h required no write",
                         cyc_cnt, rf_waddr, rf_wdata);
            end else begin
                if (rf_waddr !== sb[hit].rd || rf_wdata !== sb[hit].data) begin
                    failed++;
                    $display("FAIL rf_write cyc=%0d got x%0d=%h required x%0d=%h",
                             cyc_cnt, rf_waddr, rf_wdata, sb[hit].rd, sb[hit].data);
                end
                sb.delete(hit);
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc_cnt) begin
                tests_run++;
                failed++;
                $display("FAIL rf_missing cyc=%0d got none required x%0d=%h at cyc %0d",
                         cyc_cnt, sb[i].rd, sb[i].data, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s cyc=%0d got %h required %h",
                     name, cyc_cnt, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data,
                             input int cyc);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic idle();
        pipe_valid = 1'b0;
        pipe_rd    = '0;
        pipe_data  = '0;
        ll_valid   = 1'b0;
        ll_rd      = '0;
        ll_data    = '0;
    endtask

    initial begin
        int n;
        int j;
        int k;
        logic exp_stall;
        logic exp_ready;

        // Reset with traffic asserted.
        reset      = 1'b1;
        pipe_valid = 1'b1;
        pipe_rd    = 5'd3;
        pipe_data  = 32'hDEAD;
        ll_valid   = 1'b1;
        ll_rd      = 5'd4;
        ll_data    = 32'hBEEF;
        repeat (2) begin
            step();
            chk("rst_rf_we", 32'(rf_we), 32'd0);
            chk("rst_stall", 32'(pipe_stall), 32'd0);
            chk("rst_ll_ready", 32'(ll_ready), 32'd1);
            chk("rst_pending", ll_pending, 32'd0);
        end
        idle();
        reset = 1'b0;
        step();
        chk("post_rst_rf_we", 32'(rf_we), 32'd0);
        step();

        // Pipe beats LL in the same cycle.
        n = cyc_cnt;
        pipe_valid = 1'b1;
        pipe_rd    = 5'd5;
        pipe_data  = 32'hA;
        ll_valid   = 1'b1;
        ll_rd      = 5'd6;
        ll_data    = 32'hB;
        #1;
        chk("prio_stall", 32'(pipe_stall), 32'd0);
        chk("prio_ready", 32'(ll_ready), 32'd1);
        expect_wr(5'd5, 32'hA, n + 1);
        expect_wr(5'd6, 32'hB, n + 2);
        step();
        idle();
        chk("prio_pending", ll_pending, 32'h40);
        step();
        step();
        chk("prio_pending_clr", ll_pending, 32'd0);

        // Starvation: head denied 8 times, then one forced slot.
        n = cyc_cnt;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            pipe_valid = 1'b1;
            pipe_rd    = 5'd10;
            pipe_data  = 32'h100 + 32'(k);
            ll_valid   = (i == 0);
            ll_rd      = 5'd7;
            ll_data    = 32'h77;
            #1;
            exp_stall = (i == 9);
            chk("starve_stall", 32'(pipe_stall), 32'(exp_stall));
            if (!exp_stall) begin
                expect_wr(5'd10, 32'h100 + 32'(k), n + i + 1);
                k++;
            end else begin
                expect_wr(5'd7, 32'h77, n + i + 1);
            end
            step();
        end
        idle();
        step();
        step();

        // Full FIFO: pipe blocks the drain, 5th push is held.
        n = cyc_cnt;
        j = 0;
        for (int i = 0; i < 11; i++) begin
            pipe_valid = (i <= 4);
            pipe_rd    = 5'd20;
            pipe_data  = 32'h200 + 32'(i);
            ll_valid   = (j < 5);
            ll_rd      = 5'(11 + j);
            ll_data    = 32'h300 + 32'(j);
            #1;
            exp_ready = !(i == 4 || i == 5);
            chk("full_ready", 32'(ll_ready), 32'(exp_ready));
            chk("full_stall", 32'(pipe_stall), 32'd0);
            if (i == 4) chk("full_pending", ll_pending, 32'h7800);
            if (pipe_valid) expect_wr(5'd20, 32'h200 + 32'(i), n + i + 1);
            if (ll_valid && exp_ready) begin
                expect_wr(5'(11 + j), 32'h300 + 32'(j), n + 6 + j);
                j++;
            end
            step();
        end
        idle();
        step();
        step();

        // WAW: younger pipe write kills the queued x9.
        n = cyc_cnt;
        pipe_valid = 1'b1;
        pipe_rd    = 5'd22;
        pipe_data  = 32'h55;
        ll_valid   = 1'b1;
        ll_rd      = 5'd9;
        ll_data    = 32'h1;
        expect_wr(5'd22, 32'h55, n + 1);
        step();
        idle();
        pipe_valid = 1'b1;
        pipe_rd    = 5'd9;
        pipe_data  = 32'h2;
        #1;
        chk("waw_stall", 32'(pipe_stall), 32'd0);
        chk("waw_pending_set", ll_pending, 32'h200);
        expect_wr(5'd9, 32'h2, n + 2);
        step();
        idle();
        chk("waw_pending_clr", ll_pending, 32'd0);
        repeat (3) step();

        // Same-cycle push with matching rd survives.
        n = cyc_cnt;
        pipe_valid = 1'b1;
        pipe_rd    = 5'd12;
        pipe_data  = 32'hA1;
        ll_valid   = 1'b1;
        ll_rd      = 5'd12;
        ll_data    = 32'hB2;
        expect_wr(5'd12, 32'hA1, n + 1);
        expect_wr(5'd12, 32'hB2, n + 2);
        step();
        idle();
        chk("keep_pending", ll_pending, 32'h1000);
        step();
        step();

        // x0 streams on both sides.
        for (int i = 0; i < 6; i++) begin
            pipe_valid = 1'b1;
            pipe_rd    = 5'd0;
            pipe_data  = 32'hFF;
            ll_valid   = 1'b1;
            ll_rd      = 5'd0;
            ll_data    = 32'hEE;
            #1;
            chk("x0_stall", 32'(pipe_stall), 32'd0);
            chk("x0_ready", 32'(ll_ready), 32'd1);
            step();
        end
        idle();
        chk("x0_pending", ll_pending, 32'd0);
        n = cyc_cnt;
        ll_valid = 1'b1;
        ll_rd    = 5'd3;
        ll_data  = 32'h33;
        expect_wr(5'd3, 32'h33, n + 2);
        step();
        idle();
        step();
        step();

        // Reset mid-flight drops the queued entry.
        n = cyc_cnt;
        pipe_valid = 1'b1;
        pipe_rd    = 5'd15;
        pipe_data  = 32'h1;
        ll_valid   = 1'b1;
        ll_rd      = 5'd14;
        ll_data    = 32'h2;
        expect_wr(5'd15, 32'h1, n + 1);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_rf_we", 32'(rf_we), 32'd0);
        chk("midrst_pending", ll_pending, 32'd0);
        repeat (4) step();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
